// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM for the RV32 core.
// Sequences IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP, latches the opcode in DECODE and drives the
// datapath enables from state + latched opcode. Memory strobes are held under a req/ack
// handshake; a memory that never acks is timed out into TRAP, as is an illegal opcode.
// Saturating retired-instruction and stall-cycle counters feed the power model.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   opcode            instr[6:0], sampled only in DECODE
//   mem_ack           memory completes the current fetch/load/store this cycle
//   branch_taken      datapath compare result (consumed by the datapath, not the FSM)
//   cnt_clr           synchronous clear of both counters
//   ifetch_req        instruction read request, held through FETCH
//   ctrl_ir_w         IR load pulse
//   ctrl_pc_w         PC update pulse
//   ctrl_ALU_op       ALU operation class: ADD=0, SUB/CMP=1, FUNCT=2
//   ctrl_ALU_src      1 = immediate operand B
//   ctrl_reg_w        regfile write pulse
//   ctrl_mem_r/_w     data read/write strobes, held through MEM
//   ctrl_mem_to_reg   WB source = memory data
//   ctrl_branch       branch instruction in EXEC
//   state_o           current state encoding
//   illegal_op        sticky: TRAP entered on unsupported opcode
//   timeout_err       sticky: TRAP entered on memory timeout
//   retired_cnt       instructions retired, saturating
//   stall_cnt         FETCH/MEM cycles without ack, saturating
module multicycle_ctrl_fsm #(
  parameter int unsigned ALU_OP_W    = 2,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic                mem_ack,
  input  logic                branch_taken,
  input  logic                cnt_clr,
  output logic                ifetch_req,
  output logic                ctrl_ir_w,
  output logic                ctrl_pc_w,
  output logic [ALU_OP_W-1:0] ctrl_ALU_op,
  output logic                ctrl_ALU_src,
  output logic                ctrl_reg_w,
  output logic                ctrl_mem_r,
  output logic                ctrl_mem_w,
  output logic                ctrl_mem_to_reg,
  output logic                ctrl_branch,
  output logic [2:0]          state_o,
  output logic                illegal_op,
  output logic                timeout_err,
  output logic [CNT_W-1:0]    retired_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd7
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [ALU_OP_W-1:0] AluAdd   = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] AluSub   = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] AluFunct = ALU_OP_W'(2);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             ill_q, ill_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             retire;
  logic             stall;

  // The FSM never looks at the branch outcome; the datapath muxes the PC with it.
  logic unused_branch_taken;
  assign unused_branch_taken = branch_taken;

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    ill_d           = ill_q;
    tmo_d           = tmo_q;
    retire          = 1'b0;
    stall           = 1'b0;
    ifetch_req      = 1'b0;
    ctrl_ir_w       = 1'b0;
    ctrl_pc_w       = 1'b0;
    ctrl_ALU_op     = AluAdd;
    ctrl_ALU_src    = 1'b0;
    ctrl_reg_w      = 1'b0;
    ctrl_mem_r      = 1'b0;
    ctrl_mem_w      = 1'b0;
    ctrl_mem_to_reg = 1'b0;
    ctrl_branch     = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;

      StFetch: begin
        ifetch_req = 1'b1;
        if (mem_ack) begin
          ctrl_ir_w = 1'b1;
          state_d   = StDecode;
        end else begin
          stall = 1'b1;
          if (wait_q == WaitLast) begin
            state_d = StTrap;
            tmo_d   = 1'b1;
          end
        end
      end

      StDecode: begin
        op_d = opcode;
        case (opcode)
          OpLoad, OpStore, OpOp, OpOpImm, OpBranch, OpJal: state_d = StExec;
          default: begin
            state_d = StTrap;
            ill_d   = 1'b1;
          end
        endcase
      end

      StExec: begin
        case (op_q)
          OpLoad, OpStore: begin
            ctrl_ALU_src = 1'b1;
            state_d      = StMem;
          end
          OpOp:    begin
            ctrl_ALU_op = AluFunct;
            state_d     = StWb;
          end
          OpOpImm: begin
            ctrl_ALU_op  = AluFunct;
            ctrl_ALU_src = 1'b1;
            state_d      = StWb;
          end
          OpJal:   state_d = StWb;
          OpBranch: begin
            ctrl_ALU_op = AluSub;
            ctrl_branch = 1'b1;
            ctrl_pc_w   = 1'b1;
            retire      = 1'b1;
            state_d     = StFetch;
          end
          default: begin
            // Unreachable: DECODE only admits the opcodes above.
            state_d = StTrap;
            ill_d   = 1'b1;
          end
        endcase
      end

      StMem: begin
        if (op_q == OpLoad) begin
          ctrl_mem_r      = 1'b1;
          ctrl_mem_to_reg = 1'b1;
        end else begin
          ctrl_mem_w = 1'b1;
        end
        if (mem_ack) begin
          if (op_q == OpLoad) begin
            state_d = StWb;
          end else begin
            ctrl_pc_w = 1'b1;
            retire    = 1'b1;
            state_d   = StFetch;
          end
        end else begin
          stall = 1'b1;
          if (wait_q == WaitLast) begin
            state_d = StTrap;
            tmo_d   = 1'b1;
          end
        end
      end

      StWb: begin
        ctrl_reg_w      = 1'b1;
        ctrl_pc_w       = 1'b1;
        ctrl_mem_to_reg = (op_q == OpLoad);
        retire          = 1'b1;
        state_d         = StFetch;
      end

      StTrap: state_d = StTrap;

      default: state_d = StIdle;
    endcase

    // Any state change restarts the wait count, so each FETCH/MEM visit starts from zero.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (stall) begin
      wait_d = wait_q + WaitW'(1);
    end else begin
      wait_d = wait_q;
    end

    if (cnt_clr) begin
      ret_d = '0;
    end else if (retire && (ret_q != '1)) begin
      ret_d = ret_q + CNT_W'(1);
    end else begin
      ret_d = ret_q;
    end

    if (cnt_clr) begin
      stall_d = '0;
    end else if (stall && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      wait_q  <= '0;
      ill_q   <= 1'b0;
      tmo_q   <= 1'b0;
      ret_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      ill_q   <= ill_d;
      tmo_q   <= tmo_d;
      ret_q   <= ret_d;
      stall_q <= stall_d;
    end
  end

  assign state_o     = state_q;
  assign illegal_op  = ill_q;
  assign timeout_err = tmo_q;
  assign retired_cnt = ret_q;
  assign stall_cnt   = stall_q;

endmodule
